apply_pointer: RTL and testbench
================================

# apply_pointer

- Sequential permutation engine: the inverse of `find_pointer`.
- `find_pointer` derives, for each sorted position, the index of that element in the original array. `apply_pointer` consumes the original array plus that pointer vector and streams the reordered array.
- Sits downstream of `find_pointer` in the sort datapath. It reconstructs the sorted sequence from pointers without re-sorting.
- Ingress and egress are valid/ready streams.

## Interface
- `N`, 9, number of elements per frame
- `W`, 8, data width
- `PW`, 4, pointer width; must satisfy 2^PW ≥ N
- `clk` input 1: single clock, rising edge
- `rst_n` input 1: asynchronous active-low reset
- `in_valid` input 1: ingress pair valid
- `in_ready` output 1: ingress accept
- `in_data` input W: original-array element for slot k
- `in_ptr` input PW: pointer for output position k, 0-based index into the original array
- `out_valid` output 1: egress valid
- `out_ready` input 1: egress accept
- `out_data` output W: element at original-array index `ptr[k]`
- `out_idx` output PW: output position k
- `out_last` output 1: asserted with k = N-1
- `perm_err` output 1: frame pointer vector is not a valid permutation; exists only under the configuration macro

## Operation
- FSM states: LOAD and EMIT. Reset enters LOAD with count = 0.
- LOAD:
  - `in_ready` = 1.
  - Each transfer (`in_valid && in_ready`) writes `data_buf[count] <= in_data` and `ptr_buf[count] <= in_ptr`, then increments count.
  - The transfer with count = N-1 clears count and moves to EMIT.
- EMIT:
  - `in_ready` = 0 and `out_valid` = 1.
  - `out_idx` = count.
  - `out_data` = `data_buf[ptr_buf[count]]`.
  - `out_last` = (count == N-1).
  - Each transfer (`out_valid && out_ready`) increments count. The transfer with `out_last` clears count and returns to LOAD.
- Out-of-range pointer (`ptr_buf[count]` ≥ N): `out_data` = 0. The element is still emitted and the position is not skipped.
- Pointers are stored as received. Duplicates are emitted as duplicates.
- `data_buf` and `ptr_buf` are not cleared between frames. Every slot is overwritten in LOAD before it is read.
- Stalls:
  - `in_valid` = 0 in LOAD stalls loading with no timeout.
  - `out_ready` = 0 holds all egress outputs stable until accepted.
- Outputs are driven only from registers (state, count, buffers). There is no combinational path from any input to any output.

## Timing
- Reset values: `in_ready` = 1, `out_valid` = 0, `out_data` = 0, `out_idx` = 0, `out_last` = 0, `perm_err` = 0.
- Reset is asynchronous. Asserting `rst_n` mid-frame in either state discards the frame and returns to LOAD with count = 0.
- Ingress: one pair per cycle maximum. A frame needs N transfers, so at least N cycles.
- Latency: `out_valid` rises in the cycle after the Nth ingress transfer.
- Egress: one element per cycle at full throughput, so N cycles per frame. `in_ready` returns high in the cycle after the last egress transfer.
- Minimum frame period: 2N cycles. Load and emit do not overlap.
- No simultaneous ingress/egress event is possible, because `in_ready` and `out_valid` are mutually exclusive.

## Configuration
- Macro: `APPLY_POINTER_PERM_CHECK_EN`.
- Defined:
  - An N-bit `seen` mask is cleared at the start of every LOAD.
  - Each accepted `in_ptr` < N sets `seen[in_ptr]`.
  - `perm_err` is registered on entry to EMIT. It is 1 if any `in_ptr` ≥ N or any `in_ptr` was already set in `seen` (duplicate).
  - `perm_err` is held through EMIT and cleared on return to LOAD.
  - Egress data behaviour is unchanged.
- Undefined: no `seen` logic and no `perm_err` port.

## Structure
- Shared package `sort_pkg` holds:
  - default N/W/PW constants, shared with `find_pointer`;
  - the state enum {LOAD, EMIT};
  - the PW-wide N-1 constant.
- `data_buf`/`ptr_buf` are register arrays, not RAM, because N is small.
- One natural sub-module: `perm_checker`, which holds the `seen` mask and `perm_err`. It is instantiated only under `APPLY_POINTER_PERM_CHECK_EN`.

## Test plan
- Reverse permutation:
  - data 10,20,…,90 with ptr 8,7,…,0, `out_ready` = 1 → out_data 90,80,…,10.
  - out_idx 0..8; out_last only on idx 8.
  - `perm_err` = 0; 18 cycles total.
- Identity plus backpressure:
  - ptr 0..8, data 1..9, `out_ready` toggled 1,0,0,1 repeating → out_data 1..9 in order.
  - Outputs stable during stalls; no loss or duplication.
- Duplicate pointer:
  - ptr {4,4,0,1,2,3,5,6,7}, data 0x11..0x99 → out_data 0x55,0x55,0x11,0x22,0x33,0x44,0x66,0x77,0x88.
  - `perm_err` = 1 with the macro defined.
- Out-of-range pointer:
  - ptr[3] = 9, all other pointers valid → out_data = 0 at idx 3.
  - `perm_err` = 1 with the macro defined; port absent when undefined.
- Reset mid-EMIT:
  - Assert `rst_n` low at idx 4 → `out_valid` drops asynchronously and `in_ready` = 1.
  - A following full frame emits correctly from idx 0.
- Ingress gaps:
  - `in_valid` drops for 3 cycles between pairs 5 and 6 → no extra slots written.
  - `out_valid` rises exactly 1 cycle after the 9th accept.

Source files
------------

// File: rtl/sort_pkg.sv
// Constants and state type shared by the sort datapath (find_pointer / apply_pointer).
package sort_pkg;
  localparam int SORT_N  = 9;
  localparam int SORT_W  = 8;
  localparam int SORT_PW = 4;

  typedef enum logic {LOAD, EMIT} state_e;

  localparam logic [SORT_PW-1:0] SORT_LAST = SORT_PW'(SORT_N - 1);
endpackage

// File: rtl/apply_pointer_perm_checker.sv
// Tracks which original indices a frame's pointers hit; flags out-of-range or repeated pointers.
// Only instantiated when APPLY_POINTER_PERM_CHECK_EN is defined.
module perm_checker #(
  parameter int N  = 9,
  parameter int PW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_fire,
  input  logic          load_last,
  input  logic          emit_done,
  input  logic [PW-1:0] ptr,
  output logic          perm_err
);
  logic [N-1:0] seen_q;
  logic         acc_q;
  logic         err_q;
  logic         oob;
  logic         hit;

  always_comb begin
    oob = (int'(ptr) >= N);
    hit = oob || seen_q[ptr];
  end

  // The mask is cleared as the frame enters EMIT, so every LOAD starts clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_q <= '0;
      acc_q  <= 1'b0;
      err_q  <= 1'b0;
    end else if (load_fire) begin
      if (load_last) begin
        seen_q <= '0;
        acc_q  <= 1'b0;
        err_q  <= acc_q | hit;
      end else begin
        acc_q <= acc_q | hit;
        if (!oob) seen_q[ptr] <= 1'b1;
      end
    end else if (emit_done) begin
      err_q <= 1'b0;
    end
  end

  assign perm_err = err_q;
endmodule

// File: rtl/apply_pointer.sv
// Loads a frame of (data, pointer) pairs, then streams data[ptr[k]] for k = 0..N-1.
// Optional permutation check enabled by defining APPLY_POINTER_PERM_CHECK_EN.
module apply_pointer
  import sort_pkg::*;
#(
  parameter int N  = SORT_N,
  parameter int W  = SORT_W,
  parameter int PW = SORT_PW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic [PW-1:0] in_ptr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [PW-1:0] out_idx,
  output logic          out_last
`ifdef APPLY_POINTER_PERM_CHECK_EN
  ,
  output logic          perm_err
`endif
);
  localparam logic [PW-1:0] LAST = PW'(N - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  data_q [N];
  logic [PW-1:0] ptr_q  [N];
  logic          load_fire, emit_fire, at_last;
  logic [PW-1:0] sel_ptr;

  assign load_fire = (state_q == LOAD) && in_valid;
  assign emit_fire = (state_q == EMIT) && out_ready;
  assign at_last   = (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      LOAD: if (load_fire) begin
        cnt_d = at_last ? '0 : cnt_q + PW'(1);
        if (at_last) state_d = EMIT;
      end
      EMIT: if (emit_fire) begin
        cnt_d = at_last ? '0 : cnt_q + PW'(1);
        if (at_last) state_d = LOAD;
      end
      default: begin
        state_d = LOAD;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Buffers are never cleared between frames; LOAD overwrites every slot before EMIT reads it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        data_q[i] <= '0;
        ptr_q[i]  <= '0;
      end
    end else if (load_fire) begin
      data_q[cnt_q] <= in_data;
      ptr_q[cnt_q]  <= in_ptr;
    end
  end

  always_comb begin
    sel_ptr   = ptr_q[cnt_q];
    in_ready  = (state_q == LOAD);
    out_valid = (state_q == EMIT);
    out_idx   = out_valid ? cnt_q : '0;
    out_last  = out_valid && at_last;
    out_data  = (out_valid && int'(sel_ptr) < N) ? data_q[sel_ptr] : '0;
  end

`ifdef APPLY_POINTER_PERM_CHECK_EN
  perm_checker #(.N(N), .PW(PW)) u_perm_checker (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_fire (load_fire),
    .load_last (at_last),
    .emit_done (emit_fire && at_last),
    .ptr       (in_ptr),
    .perm_err  (perm_err)
  );
`endif
endmodule

// File: tb/tb_apply_pointer.sv
// Randomized + directed scoreboard bench for apply_pointer (perm_err checked when
// APPLY_POINTER_PERM_CHECK_EN is defined).
module tb_apply_pointer;
  import sort_pkg::*;
  localparam int N = SORT_N, W = SORT_W, PW = SORT_PW;

  logic clk, rst_n, in_valid, in_ready, out_valid, out_ready, out_last;
  logic [W-1:0] in_data, out_data;
  logic [PW-1:0] in_ptr, out_idx;
`ifdef APPLY_POINTER_PERM_CHECK_EN
  logic perm_err;
`endif

  apply_pointer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ptr(in_ptr), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last)
`ifdef APPLY_POINTER_PERM_CHECK_EN
    , .perm_err(perm_err)
`endif
  );

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct {int d; int idx; int last; int err;} exp_t;
  exp_t sb[$];
  int passed = 0, total = 0;
  int rdy_mode = 0, ph = 0;
  int fd [N];
  int fp [N];

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Egress backpressure generator: 0 always ready, 1 pattern 1,0,0,1, 2 random.
  always @(posedge clk) begin
    #1;
    ph++;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = (ph % 4 == 0) || (ph % 4 == 3);
      2: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: pops the scoreboard on every egress transfer, checks stall stability.
  logic hv = 0;
  int hd, hi, hl;
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (hv) begin
        chk("stall_data", out_data, hd);
        chk("stall_idx", out_idx, hi);
        chk("stall_last", out_last, hl);
      end
      chk("in_ready_low_in_emit", in_ready, 0);
      if (out_ready) begin
        hv = 0;
        if (sb.size() == 0) chk("unexpected_output", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_idx", out_idx, e.idx);
          chk("out_last", out_last, e.last);
`ifdef APPLY_POINTER_PERM_CHECK_EN
          chk("perm_err", perm_err, e.err);
`endif
        end
      end else begin
        hv = 1; hd = out_data; hi = out_idx; hl = out_last;
      end
    end else hv = 0;
  end

  // Reference: out[k] = data[ptr[k]] when ptr[k] < N else 0; error if any ptr is out of range or repeats.
  task automatic push_expected();
    int cnt [16];
    int err = 0;
    foreach (cnt[i]) cnt[i] = 0;
    for (int k = 0; k < N; k++) begin
      if (fp[k] >= N) err = 1;
      else begin
        cnt[fp[k]]++;
        if (cnt[fp[k]] > 1) err = 1;
      end
    end
    for (int k = 0; k < N; k++) begin
      exp_t e;
      e.d = (fp[k] < N) ? fd[fp[k]] : 0;
      e.idx = k;
      e.last = (k == N - 1);
      e.err = err;
      sb.push_back(e);
    end
  endtask

  task automatic send_frame(input int gapk, input int rnd_gaps);
    int t = 0;
    while (!in_ready && t < 1000) begin @(posedge clk); #1; t++; end
    chk("wait_in_ready_timeout", in_ready, 1);
    push_expected();
    for (int k = 0; k < N; k++) begin
      int idle = (k == gapk) ? 3 : 0;
      if (rnd_gaps && $urandom_range(0, 3) == 0) idle = $urandom_range(1, 2);
      repeat (idle) begin
        in_valid = 0; in_data = W'($urandom); in_ptr = PW'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1; in_data = W'(fd[k]); in_ptr = PW'(fp[k]);
      if (k == N - 1) chk("no_early_valid", out_valid, 0);
      @(posedge clk); #1;
      in_valid = 0; in_data = W'($urandom); in_ptr = PW'($urandom);
    end
    chk("latency_valid", out_valid, 1);
  endtask

  task automatic drain(output int n);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!in_ready && n < 1000);
    chk("drain_timeout", in_ready, 1);
    chk("sb_empty", sb.size(), 0);
  endtask

  task automatic rand_frame();
    for (int k = 0; k < N; k++) begin fd[k] = $urandom_range(0, 255); fp[k] = k; end
    for (int k = N - 1; k > 0; k--) begin
      int j = $urandom_range(0, k);
      int tmp = fp[k]; fp[k] = fp[j]; fp[j] = tmp;
    end
    if ($urandom_range(0, 2) == 0) fp[$urandom_range(0, N - 1)] = $urandom_range(0, 15);
  endtask

  initial begin
    int n;
    rst_n = 0; in_valid = 0; in_data = 0; in_ptr = 0; out_ready = 1;
    #13;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_last", out_last, 0);
`ifdef APPLY_POINTER_PERM_CHECK_EN
    chk("rst_perm_err", perm_err, 0);
`endif
    #10 rst_n = 1;
    @(posedge clk); #1;

    // Reverse permutation, full throughput: 9 load + 9 emit cycles.
    rdy_mode = 0;
    for (int k = 0; k < N; k++) begin fd[k] = 10 * (k + 1); fp[k] = N - 1 - k; end
    send_frame(-1, 0); drain(n);
    chk("reverse_emit_cycles", n, N);

    // Identity with 1,0,0,1 backpressure.
    rdy_mode = 1;
    for (int k = 0; k < N; k++) begin fd[k] = k + 1; fp[k] = k; end
    send_frame(-1, 0); drain(n);

    // Duplicate pointer.
    rdy_mode = 0;
    fp = '{4, 4, 0, 1, 2, 3, 5, 6, 7};
    for (int k = 0; k < N; k++) fd[k] = 'h11 * (k + 1);
    send_frame(-1, 0); drain(n);

    // Out-of-range pointer at idx 3.
    for (int k = 0; k < N; k++) begin fd[k] = $urandom_range(1, 255); fp[k] = k; end
    fp[3] = 9;
    send_frame(-1, 0); drain(n);

    // Reset mid-EMIT at idx 4, then a clean frame.
    for (int k = 0; k < N; k++) begin fd[k] = 10 * (k + 1); fp[k] = N - 1 - k; end
    send_frame(-1, 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!(out_valid && out_idx == 4) && n < 100);
    chk("reach_idx4", out_idx, 4);
    #2 rst_n = 0;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_in_ready", in_ready, 1);
    sb.delete();
    @(posedge clk); #2 rst_n = 1;
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) begin fd[k] = k + 1; fp[k] = k; end
    send_frame(-1, 0); drain(n);

    // Ingress gap of 3 cycles between pairs 5 and 6.
    rand_frame();
    for (int k = 0; k < N; k++) fp[k] = (k + 3) % N;
    send_frame(5, 0); drain(n);

    // Randomized frames with random gaps and backpressure.
    rdy_mode = 2;
    for (int f = 0; f < 25; f++) begin
      rand_frame();
      send_frame(-1, 1); drain(n);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
